// File: rtl/present_enc_iter.sv
// present_enc_iter: iterative PRESENT block encryptor with an M/K valid/ready input handshake
// and a C valid/ready output handshake. UNROLL rounds are chained combinationally per clock.
// The last cycle bypasses any rounds past NROUNDS, so state and key see exactly NROUNDS updates.
//
// Parameters:
//   UNROLL  (1..8)  rounds computed per clock
//   NROUNDS (1..31) rounds applied before the final round-key addition
// Configuration macro:
//   PRESENT_KEY128_EN  defined: 128-bit key and key schedule; undefined: 80-bit key (default)
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   i_k          cipher key (80 or 128 bits), sampled on accept
//   i_m          64-bit plaintext, sampled on accept
//   i_in_valid   M/K valid
//   o_in_ready   block idle and able to accept
//   o_c          64-bit ciphertext, registered
//   o_out_valid  ciphertext valid, held until the output handshake
//   i_out_ready  consumer accepts ciphertext
module present_enc_iter #(
    parameter int unsigned UNROLL  = 1,
    parameter int unsigned NROUNDS = 31,
`ifdef PRESENT_KEY128_EN
    localparam int unsigned KW = 128
`else
    localparam int unsigned KW = 80
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [KW-1:0] i_k,
    input  logic [63:0]   i_m,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic [63:0]   o_c,
    output logic          o_out_valid,
    input  logic          i_out_ready
);

    if (UNROLL < 1 || UNROLL > 8) begin : g_bad_unroll
        $error("present_enc_iter: UNROLL must be in 1..8");
    end
    if (NROUNDS < 1 || NROUNDS > 31) begin : g_bad_nrounds
        $error("present_enc_iter: NROUNDS must be in 1..31");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

    fsm_e            r_fsm;
    fsm_e            w_fsm_next;
    logic [63:0]     r_data;
    logic [KW-1:0]   r_key;
    logic [4:0]      r_rnd;
    logic [63:0]     r_c;
    logic [63:0]     w_state;
    logic [KW-1:0]   w_key;
    logic            w_last;
    logic            w_accept;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 maps onto itself.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 63; i++) begin
            y[(16 * i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

`ifdef PRESENT_KEY128_EN
    function automatic logic [127:0] key_update(input logic [127:0] k, input logic [4:0] rc);
        logic [127:0] t;
        t          = {k[66:0], k[127:67]};
        t[127:124] = sbox(t[127:124]);
        t[123:120] = sbox(t[123:120]);
        t[66:62]   = t[66:62] ^ rc;
        return t;
    endfunction
`else
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] t;
        t        = {k[18:0], k[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction
`endif

    // Unrolled round chain; a stage whose round index exceeds NROUNDS passes through unchanged.
    always_comb begin
        w_state = r_data;
        w_key   = r_key;
        for (int unsigned j = 0; j < UNROLL; j++) begin
            if (({1'b0, r_rnd} + 6'(j)) <= 6'(NROUNDS)) begin
                w_state = p_layer(s_layer(w_state ^ w_key[KW-1 -: 64]));
                w_key   = key_update(w_key, r_rnd + 5'(j));
            end
        end
    end

    assign w_last   = ({1'b0, r_rnd} + 6'(UNROLL)) > 6'(NROUNDS);
    assign w_accept = (r_fsm == StIdle) && i_in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= StIdle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            StIdle: if (i_in_valid) w_fsm_next = StRun;
            StRun:  if (w_last) w_fsm_next = StDone;
            StDone: if (i_out_ready) w_fsm_next = StIdle;
            default: w_fsm_next = StIdle;
        endcase
    end

    // Round counter stops advancing on the final RUN edge so it never exceeds NROUNDS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_key  <= '0;
            r_rnd  <= '0;
            r_c    <= '0;
        end else if (w_accept) begin
            r_data <= i_m;
            r_key  <= i_k;
            r_rnd  <= 5'd1;
        end else if (r_fsm == StRun) begin
            r_data <= w_state;
            r_key  <= w_key;
            if (w_last) begin
                r_c <= w_state ^ w_key[KW-1 -: 64];
            end else begin
                r_rnd <= r_rnd + 5'(UNROLL);
            end
        end
    end

    assign o_in_ready  = (r_fsm == StIdle);
    assign o_out_valid = (r_fsm == StDone);
    assign o_c         = r_c;

endmodule

// File: tb/tb_present_enc_iter.sv
// tb_present_enc_iter: scoreboard bench for present_enc_iter. Two instances (UNROLL=1 and
// UNROLL=3) share the input stream; each has its own output monitor, random backpressure and
// expected-result queue. Expected ciphertexts come from known-answer constants or a plain
// behavioural PRESENT model.
module tb_present_enc_iter;

`ifdef PRESENT_KEY128_EN
    localparam int unsigned KW = 128;
`else
    localparam int unsigned KW = 80;
`endif
    localparam int unsigned NR    = 31;
    localparam int unsigned U_A   = 1;
    localparam int unsigned U_B   = 3;
    localparam int          LAT_A = (NR + U_A - 1) / U_A;
    localparam int          LAT_B = (NR + U_B - 1) / U_B;

    typedef struct {
        logic [63:0] c;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [63:0]   i_m;
    logic [KW-1:0] i_k;
    logic          iv;
    logic [1:0]    ir;
    logic [1:0]    ov;
    logic [1:0]    ordy;
    logic [63:0]   c0;
    logic [63:0]   c1;
    logic [1:0]    bp;

    int            cyc = 0;
    int            npass = 0;
    int            ntot = 0;
    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [1:0]    pend;
    logic [1:0]    hs;
    int            hold[2];
    logic [63:0]   held[2];

    present_enc_iter #(.UNROLL(U_A), .NROUNDS(NR)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .i_k        (i_k),
        .i_m        (i_m),
        .i_in_valid (iv),
        .o_in_ready (ir[0]),
        .o_c        (c0),
        .o_out_valid(ov[0]),
        .i_out_ready(ordy[0])
    );

    present_enc_iter #(.UNROLL(U_B), .NROUNDS(NR)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .i_k        (i_k),
        .i_m        (i_m),
        .i_in_valid (iv),
        .o_in_ready (ir[1]),
        .o_c        (c1),
        .o_out_valid(ov[1]),
        .i_out_ready(ordy[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        ntot++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Behavioural PRESENT: add round key, substitute nibbles, permute bits, schedule key.
    function automatic logic [63:0] ref_enc(input logic [63:0] m, input logic [KW-1:0] k0);
        int            sb[16];
        logic [63:0]   s;
        logic [63:0]   t;
        logic [KW-1:0] k;
        sb = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
        s  = m;
        k  = k0;
        for (int r = 1; r <= int'(NR); r++) begin
            s = s ^ k[KW-1 -: 64];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
            t = '0;
            for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (16 * i) % 63] = s[i];
            s = t;
            k = (k << 61) | (k >> (KW - 61));
            k[KW-1 -: 4] = 4'(sb[k[KW-1 -: 4]]);
`ifdef PRESENT_KEY128_EN
            k[KW-5 -: 4] = 4'(sb[k[KW-5 -: 4]]);
            k[66:62]     = k[66:62] ^ 5'(r);
`else
            k[19:15]     = k[19:15] ^ 5'(r);
`endif
        end
        return s ^ k[KW-1 -: 64];
    endfunction

    // Output monitor: compares on out_valid rise, checks stability while held, drives out_ready.
    always @(negedge clk) begin
        logic [63:0] cur;
        logic        hs_prev;
        exp_t        e;
        for (int d = 0; d < 2; d++) begin
            cur     = (d == 0) ? c0 : c1;
            hs_prev = hs[d];
            hs[d]   = 1'b0;
            if (rst) begin
                pend[d] = 1'b0;
                ordy[d] = 1'b0;
            end else if (ov[d]) begin
                if (!pend[d]) begin
                    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
                        fail_now((d == 0) ? "unexpected_out_a" : "unexpected_out_b");
                    end else begin
                        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                        check((d == 0) ? "c_a" : "c_b", cur, e.c);
                        check((d == 0) ? "latency_a" : "latency_b", 64'(cyc - e.cyc),
                              64'((d == 0) ? LAT_A : LAT_B));
                    end
                    pend[d] = 1'b1;
                    held[d] = cur;
                    hold[d] = bp[d] ? 10 : int'($urandom_range(0, 3));
                end else begin
                    check((d == 0) ? "c_stable_a" : "c_stable_b", cur, held[d]);
                end
                check((d == 0) ? "in_ready_done_a" : "in_ready_done_b", 64'(ir[d]), 64'(0));
                ordy[d] = (hold[d] == 0);
                if (hold[d] > 0) hold[d]--;
                if (ordy[d]) begin
                    pend[d] = 1'b0;
                    hs[d]   = 1'b1;
                end
            end else begin
                if (hs_prev) check((d == 0) ? "idle_after_hs_a" : "idle_after_hs_b",
                                   64'(ir[d]), 64'(1));
                if (pend[d]) fail_now((d == 0) ? "valid_dropped_a" : "valid_dropped_b");
                pend[d] = 1'b0;
                ordy[d] = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send(input logic [63:0] m, input logic [KW-1:0] k, input bit kat_en,
                        input logic [63:0] kat);
        int             w;
        exp_t           e;
        logic [127:0]   rk;
        w = 0;
        while (ir != 2'b11 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            fail_now("accept_timeout");
            return;
        end
        i_m = m;
        i_k = k;
        iv  = 1'b1;
        @(posedge clk);
        #1;
        e.c   = kat_en ? kat : ref_enc(m, k);
        e.cyc = cyc;
        q_a.push_back(e);
        q_b.push_back(e);
        // Keep in_valid high with changing M/K while both instances are busy.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rk  = {$urandom, $urandom, $urandom, $urandom};
            i_m = {$urandom, $urandom};
            i_k = rk[KW-1:0];
        end
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic send_rand();
        logic [127:0] rk;
        rk = {$urandom, $urandom, $urandom, $urandom};
        send({$urandom, $urandom}, rk[KW-1:0], 1'b0, 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_c_a", c0, 64'h0);
        check("rst_c_b", c1, 64'h0);
        check("rst_out_valid", 64'(ov), 64'(0));
        check("rst_in_ready", 64'(ir), 64'(3));
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || pend != 2'b00) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 3000) fail_now("drain_timeout");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        iv   = 1'b0;
        i_m  = '0;
        i_k  = '0;
        bp   = 2'b00;
        pend = 2'b00;
        hs   = 2'b00;
        ordy = 2'b00;
        do_reset();

`ifdef PRESENT_KEY128_EN
        send(64'h0, '0, 1'b1, 64'h96DB702A2E6900AF);
`else
        send(64'h0, '0, 1'b1, 64'h5579C1387B228445);
        send(64'h0, '1, 1'b1, 64'hE72C46C0F5945049);
        send('1, '1, 1'b1, 64'h3333DCD3213210D2);
        send('1, '0, 1'b1, 64'hA112FFC72F68417B);
`endif
        bp = 2'b11;
        send_rand();
        drain();
        bp = 2'b00;

        // Abort mid-operation, then accept on the first edge after reset.
        send_rand();
        repeat (8) @(posedge clk);
        do_reset();
`ifdef PRESENT_KEY128_EN
        send(64'h0, '0, 1'b1, 64'h96DB702A2E6900AF);
`else
        send(64'h0, '0, 1'b1, 64'h5579C1387B228445);
`endif

        for (int i = 0; i < 12; i++) send_rand();
        drain();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/present_enc_iter.md
PRESENT_ENC_ITER -- requirements
Module: present_enc_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1: PRESENT rounds computed per clock; legal range 1..8.
REQ-002 SHALL have parameter NROUNDS, default 31: rounds before final key addition; legal range 1..31.
REQ-003 SHALL reject illegal UNROLL or NROUNDS at elaboration.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 K  input  80 (128 with PRESENT_KEY128_EN)  cipher key, sampled on accept.
REQ-007 M  input  64  plaintext, sampled on accept.
REQ-008 in_valid  input  1  M/K valid.
REQ-009 in_ready  output  1  block can accept M/K.
REQ-010 C  output  64  ciphertext, registered.
REQ-011 out_valid  output  1  C valid.
REQ-012 out_ready  input  1  consumer accepts C.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-014 Output handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1, out_valid=0; on accept, load state=M, key=K, round counter r=1, go to RUN.
REQ-017 RUN: in_ready=0, out_valid=0; each edge applies min(UNROLL, NROUNDS-r+1) rounds, combinationally chained.
REQ-018 Round r: state = pLayer(sBoxLayer(state XOR key[top 64])); key = update(key, r); r = r+1.
REQ-019 80-bit key update: rotate left 61; S-box on bits 79:76; XOR 5-bit r into bits 19:15.
REQ-020 The PRESENT S-box SHALL be C56B90AD3EF84712 (input 0..F).
REQ-021 pLayer: state bit i SHALL move to bit 16*i mod 63, with bit 63 fixed.
REQ-022 On the edge completing round NROUNDS, C SHALL load state XOR key[top 64] (post-update key); FSM goes to DONE.
REQ-023 Latency: out_valid SHALL rise ceil(NROUNDS/UNROLL) edges after accept edge (31 for defaults; 8 for UNROLL=4).
REQ-024 Rounds beyond NROUNDS in the last RUN cycle SHALL be bypassed; state and key are unaffected by them.
REQ-025 DONE: out_valid=1, in_ready=0; C and out_valid SHALL hold stable until the output handshake.
REQ-026 On output handshake the FSM SHALL go to IDLE; a new accept is possible on the next edge, not the same edge.
REQ-027 in_valid while not in IDLE SHALL be ignored; M/K changes after accept SHALL not affect the result.
REQ-028 Round counter SHALL be 5 bits and never wrap within an operation.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, C=0, internal state/key/r=0.
REQ-030 Reset during RUN or DONE SHALL abort the operation, with no output handshake for it.
REQ-031 After rst deassertion, an accept SHALL be possible on the first rising edge.

Configuration
REQ-032 Macro PRESENT_KEY128_EN SHALL select key length; UNROLL, NROUNDS, latency and handshake SHALL be identical in both modes.
REQ-033 Without PRESENT_KEY128_EN: K SHALL be 80 bits and the key register 80 bits, using the REQ-019 update.
REQ-034 With PRESENT_KEY128_EN: K SHALL be 128 bits and the key register 128 bits.
REQ-035 With PRESENT_KEY128_EN the 128-bit key update SHALL be: rotate left 61; S-box on bits 127:124 and 123:120; XOR r into bits 66:62.
REQ-036 In both modes the round key SHALL be key register top 64 bits.

Verification
REQ-037 Defaults, M=0, K=0 -> C=5579C1387B228445, out_valid exactly 31 edges after accept.
REQ-038 Defaults, M=0, K=all-ones -> C=E72C46C0F5945049; then M=all-ones, K=all-ones -> C=3333DCD3213210D2.
REQ-039 UNROLL=4 and UNROLL=3, M=all-ones, K=0 -> C=A112FFC72F68417B after 8 and 11 edges respectively.
REQ-040 Backpressure: out_ready=0 for 10 cycles after out_valid -> C stable, in_ready=0, new in_valid ignored; handshake -> IDLE next edge.
REQ-041 rst pulse at round 15, then M=0, K=0 -> out_valid low throughout, second result 5579C1387B228445 in normal latency.
REQ-042 PRESENT_KEY128_EN, M=0, K=0 -> C=96DB702A2E6900AF.
